ioctl_ram_loader: RTL and testbench

- Generalised successor to the byte-wide download path: turns the HPS ioctl byte stream into DATA_W-wide RAM write requests.
- Packs bytes into words and buffers them in a small FIFO. Maps each ioctl_index to its own RAM region, and throttles the HPS through ioctl_wait.
- Sits between hps_io and the SDRAM controller inside the core top; the controller acknowledges each request with a one-cycle ram_ack.

---
 rtl/ioctl_ram_loader.sv | 175 +++++++++++++++++
 tb/tb_ioctl_ram_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_ram_loader.sv
// Packs the hps_io ioctl byte stream into DATA_W-wide RAM write requests,
// one address region per ioctl_index, buffered by a small write FIFO.
module ioctl_ram_loader #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 25,
  parameter int FIFO_DEPTH   = 8,
  parameter int NUM_IDX      = 4,
  parameter int REGION_SHIFT = 20
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ioctl_download,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_wr,
  input  logic [26:0]         ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  output logic                ioctl_wait,
  output logic                ram_req,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_din,
  output logic [DATA_W/8-1:0] ram_be,
  input  logic                ram_ack,
  output logic                busy,
  output logic                done,
  output logic [26:0]         byte_count,
  output logic                overflow
);
  localparam int BYTES = DATA_W / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int LW    = (LB > 0) ? LB : 1;
  localparam int IDX_W = (NUM_IDX > 1) ? $clog2(NUM_IDX) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BYTES-1:0]  be;
  } word_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic              dl_q, pend;
  logic [26:0]       acc_waddr;
  logic [IDX_W-1:0]  acc_idx;
  logic [DATA_W-1:0] acc_data;
  logic [BYTES-1:0]  acc_be;

  word_t             mem [FIFO_DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [CW-1:0]     count;

  function automatic logic [ADDR_W-1:0] mk_addr(input logic [IDX_W-1:0] i, input logic [26:0] w);
    mk_addr = (ADDR_W'(i) << REGION_SHIFT) + ADDR_W'(w);
  endfunction

  logic [LW-1:0]     lane;
  logic [26:0]       waddr;
  logic [IDX_W-1:0]  idx;
  logic              take, acc_hit, last_lane, closing;
  logic              push0, push1, acc0, acc1, drop, pop;
  logic [CW-1:0]     room;
  logic [DATA_W-1:0] new_data;
  logic [BYTES-1:0]  new_be;
  word_t             w0, w1;

  assign lane      = LW'(ioctl_addr & 27'(BYTES - 1));
  assign waddr     = ioctl_addr >> LB;
  assign idx       = ioctl_index[IDX_W-1:0];
  assign take      = ioctl_download & ioctl_wr & ({1'b0, ioctl_index} < 9'(NUM_IDX)) & (state == S_LOAD);
  assign acc_hit   = (acc_be != '0) && (acc_waddr == waddr) && (acc_idx == idx);
  assign last_lane = (lane == LW'(BYTES - 1));
  assign closing   = (state == S_LOAD) && !ioctl_download;

  // Byte merges into the open word when it hits the same word, else starts fresh.
  always_comb begin
    new_data = acc_hit ? acc_data : '0;
    new_be   = acc_hit ? acc_be : '0;
    for (int b = 0; b < BYTES; b++) begin
      if (lane == LW'(b)) begin
        new_data[b*8 +: 8] = ioctl_dout;
        new_be[b]          = 1'b1;
      end
    end
  end

  // Up to two pushes per cycle: the evicted old word and the just-completed new one.
  assign push0 = (take && acc_be != '0 && !acc_hit) || (closing && acc_be != '0);
  assign push1 = take && last_lane;
  assign room  = CW'(FIFO_DEPTH) - count;
  assign acc0  = push0 && (room != '0);
  assign acc1  = push1 && (room > CW'(acc0));
  assign drop  = (push0 && !acc0) || (push1 && !acc1);
  assign pop   = (count != '0) && (!ram_req || ram_ack);

  assign w0 = '{addr: mk_addr(acc_idx, acc_waddr), data: acc_data, be: acc_be};
  assign w1 = '{addr: mk_addr(idx, waddr), data: new_data, be: new_be};

  always_ff @(posedge clk_sys) begin
    if (acc0) mem[wp] <= w0;
    if (acc1) mem[acc0 ? wp + PW'(1) : wp] <= w1;
  end

  always_ff @(posedge clk_sys) begin
    dl_q <= ioctl_download;
    if (!reset_n) begin
      state      <= S_IDLE;
      pend       <= 1'b0;
      acc_waddr  <= '0;
      acc_idx    <= '0;
      acc_data   <= '0;
      acc_be     <= '0;
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
      ram_req    <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      ram_be     <= '0;
      byte_count <= '0;
      overflow   <= 1'b0;
    end else begin
      // Remember a download that starts while the previous one is still draining.
      if (!ioctl_download)                 pend <= 1'b0;
      else if (!dl_q && state != S_IDLE)   pend <= 1'b1;

      case (state)
        S_IDLE:  if (ioctl_download && (!dl_q || pend)) begin
                   state      <= S_LOAD;
                   pend       <= 1'b0;
                   byte_count <= '0;
                   overflow   <= 1'b0;
                 end
        S_LOAD:  if (!ioctl_download) state <= S_DRAIN;
        S_DRAIN: if (count == '0 && !ram_req) state <= S_DONE;
        default: state <= S_IDLE;
      endcase

      if (take) begin
        byte_count <= byte_count + 27'd1;
        if (push1) acc_be <= '0;
        else begin
          acc_waddr <= waddr;
          acc_idx   <= idx;
          acc_data  <= new_data;
          acc_be    <= new_be;
        end
      end else if (closing) begin
        acc_be <= '0;
      end

      if (drop) overflow <= 1'b1;

      wp    <= wp + PW'(acc0) + PW'(acc1);
      count <= count + CW'(acc0) + CW'(acc1) - CW'(pop);

      if (pop) begin
        ram_req  <= 1'b1;
        ram_addr <= mem[rp].addr;
        ram_din  <= mem[rp].data;
        ram_be   <= mem[rp].be;
        rp       <= rp + PW'(1);
      end else if (ram_ack) begin
        ram_req <= 1'b0;
      end
    end
  end

  assign ioctl_wait = ((state == S_LOAD) && (count >= CW'(FIFO_DEPTH - 2))) ||
                      (state == S_DRAIN) || (state == S_DONE);
  assign busy       = (state == S_LOAD) || (state == S_DRAIN);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_ioctl_ram_loader.sv
// Directed bench for ioctl_ram_loader (DATA_W=16, FIFO_DEPTH=8, NUM_IDX=4).
module tb_ioctl_ram_loader;
  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [26:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        ram_req;
  logic [24:0] ram_addr;
  logic [15:0] ram_din;
  logic [1:0]  ram_be;
  logic        ram_ack = 1'b0;
  logic        busy, done, overflow;
  logic [26:0] byte_count;

  ioctl_ram_loader #(.DATA_W(16), .ADDR_W(25), .FIFO_DEPTH(8), .NUM_IDX(4), .REGION_SHIFT(20)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .ram_req(ram_req),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_be(ram_be), .ram_ack(ram_ack),
    .busy(busy), .done(done), .byte_count(byte_count), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad = 0;
  bit ack_en = 1'b0;

  // RAM controller model: acks one cycle after a request is seen, logs each accepted word.
  int          n_log = 0;
  logic [24:0] log_addr [64];
  logic [15:0] log_din  [64];
  logic [1:0]  log_be   [64];

  always @(posedge clk_sys) begin
    #2;
    ram_ack = ack_en && ram_req && !ram_ack;
    if (ram_ack && n_log < 64) begin
      log_addr[n_log] = ram_addr;
      log_din[n_log]  = ram_din;
      log_be[n_log]   = ram_be;
      n_log = n_log + 1;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic wr_byte(input logic [26:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_done(output int dcnt);
    dcnt = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (done === 1'b1) dcnt++;
      if (dcnt > 0 && done === 1'b0) break;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done === 1'b1) dcnt++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0;
    ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = 8'd0;
    repeat (3) tick();
    total++; if (ram_req !== 1'b0) begin bad++; $display("FAIL reset_ram_req got=%0b want=0", ram_req); end
    total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL reset_wait got=%0b want=0", ioctl_wait); end
    total++; if ({busy, done, overflow} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, overflow}); end
    total++; if (byte_count !== 27'd0) begin bad++; $display("FAIL reset_byte_count got=%0d want=0", byte_count); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int base, dcnt;
    base = n_log; ack_en = 1'b1;
    start_dl(8'd0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%0b want=1", busy); end
    wr_byte(27'd0, 8'h11);
    wr_byte(27'd1, 8'h22);
    total++; if (ram_req !== 1'b0) begin bad++; $display("FAIL basic_lat1 ram_req got=%0b want=0", ram_req); end
    wr_byte(27'd2, 8'h33);
    total++; if (ram_req !== 1'b1 || ram_din !== 16'h2211) begin bad++; $display("FAIL basic_lat2 req=%0b din=%h want req=1 din=2211", ram_req, ram_din); end
    wr_byte(27'd3, 8'h44);
    end_dl();
    wait_done(dcnt);
    total++; if (n_log - base !== 2) begin bad++; $display("FAIL basic_nreq got=%0d want=2", n_log - base); end
    total++; if (log_addr[base] !== 25'd0 || log_din[base] !== 16'h2211 || log_be[base] !== 2'b11) begin bad++; $display("FAIL basic_w0 addr=%h din=%h be=%b want 0 2211 11", log_addr[base], log_din[base], log_be[base]); end
    total++; if (log_addr[base+1] !== 25'd1 || log_din[base+1] !== 16'h4433 || log_be[base+1] !== 2'b11) begin bad++; $display("FAIL basic_w1 addr=%h din=%h be=%b want 1 4433 11", log_addr[base+1], log_din[base+1], log_be[base+1]); end
    total++; if (byte_count !== 27'd4) begin bad++; $display("FAIL basic_count got=%0d want=4", byte_count); end
    total++; if (dcnt !== 1) begin bad++; $display("FAIL basic_done got=%0d want=1", dcnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%0b want=0", busy); end
  endtask

  task automatic test_odd_length();
    int base, dcnt;
    base = n_log; ack_en = 1'b1;
    start_dl(8'd0);
    wr_byte(27'd0, 8'hAA);
    wr_byte(27'd1, 8'hBB);
    wr_byte(27'd2, 8'hCC);
    repeat (5) tick();
    total++; if (n_log - base !== 1 || ram_req !== 1'b0) begin bad++; $display("FAIL odd_early nreq=%0d req=%0b want 1 0", n_log - base, ram_req); end
    end_dl();
    wait_done(dcnt);
    total++; if (n_log - base !== 2) begin bad++; $display("FAIL odd_nreq got=%0d want=2", n_log - base); end
    total++; if (log_addr[base+1] !== 25'd1 || log_din[base+1][7:0] !== 8'hCC || log_be[base+1] !== 2'b01) begin bad++; $display("FAIL odd_tail addr=%h din=%h be=%b want 1 xxCC 01", log_addr[base+1], log_din[base+1], log_be[base+1]); end
  endtask

  task automatic test_region();
    int base, dcnt;
    base = n_log; ack_en = 1'b1;
    start_dl(8'd2);
    wr_byte(27'h10, 8'h5A);
    end_dl();
    wait_done(dcnt);
    total++; if (n_log - base !== 1) begin bad++; $display("FAIL region_nreq got=%0d want=1", n_log - base); end
    total++; if (log_addr[base] !== 25'h200008 || log_din[base][7:0] !== 8'h5A || log_be[base] !== 2'b01) begin bad++; $display("FAIL region_word addr=%h din=%h be=%b want 200008 xx5A 01", log_addr[base], log_din[base], log_be[base]); end
  endtask

  task automatic test_bad_index();
    int base, dcnt;
    base = n_log; ack_en = 1'b1;
    start_dl(8'd7);
    wr_byte(27'd0, 8'h01);
    wr_byte(27'd1, 8'h02);
    wr_byte(27'd2, 8'h03);
    end_dl();
    wait_done(dcnt);
    total++; if (n_log - base !== 0) begin bad++; $display("FAIL badidx_nreq got=%0d want=0", n_log - base); end
    total++; if (byte_count !== 27'd0 || overflow !== 1'b0) begin bad++; $display("FAIL badidx_stat count=%0d ovf=%0b want 0 0", byte_count, overflow); end
    total++; if (dcnt !== 1) begin bad++; $display("FAIL badidx_done got=%0d want=1", dcnt); end
  endtask

  task automatic test_backpressure();
    int base, dcnt;
    base = n_log; ack_en = 1'b0;
    start_dl(8'd0);
    for (int k = 0; k < 20; k++) begin
      wr_byte(27'(2*k), 8'(k));
      wr_byte(27'(2*k+1), 8'(k + 128));
      if (k == 5) begin
        total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL bp_wait_occ5 got=%0b want=0", ioctl_wait); end
      end
      if (k == 6) begin
        total++; if (ioctl_wait !== 1'b1) begin bad++; $display("FAIL bp_wait_occ6 got=%0b want=1", ioctl_wait); end
      end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_overflow got=%0b want=1", overflow); end
    end_dl();
    total++; if (ioctl_wait !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL bp_drain wait=%0b busy=%0b want 1 1", ioctl_wait, busy); end
    repeat (4) tick();
    ack_en = 1'b1;
    wait_done(dcnt);
    total++; if (n_log - base !== 9) begin bad++; $display("FAIL bp_nreq got=%0d want=9", n_log - base); end
    for (int j = 0; j < 9; j++) begin
      total++;
      if (log_addr[base+j] !== 25'(j) || log_din[base+j] !== {8'(j + 128), 8'(j)} || log_be[base+j] !== 2'b11) begin
        bad++; $display("FAIL bp_order[%0d] addr=%h din=%h be=%b want %h %h 11", j, log_addr[base+j], log_din[base+j], log_be[base+j], 25'(j), {8'(j + 128), 8'(j)});
      end
    end
    total++; if (byte_count !== 27'd40 || dcnt !== 1) begin bad++; $display("FAIL bp_end count=%0d done=%0d want 40 1", byte_count, dcnt); end
  endtask

  task automatic test_reset_mid_load();
    int base, dcnt;
    ack_en = 1'b0;
    start_dl(8'd0);
    for (int k = 0; k < 3; k++) begin
      wr_byte(27'(2*k), 8'hE0);
      wr_byte(27'(2*k+1), 8'hE1);
    end
    total++; if (ram_req !== 1'b1) begin bad++; $display("FAIL rst_pre_req got=%0b want=1", ram_req); end
    reset_n = 1'b0; ioctl_download = 1'b0;
    tick();
    reset_n = 1'b1;
    total++; if (ram_req !== 1'b0 || busy !== 1'b0 || ioctl_wait !== 1'b0) begin bad++; $display("FAIL rst_state req=%0b busy=%0b wait=%0b want 0 0 0", ram_req, busy, ioctl_wait); end
    total++; if (byte_count !== 27'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", byte_count); end
    base = n_log; ack_en = 1'b1;
    repeat (6) tick();
    total++; if (n_log - base !== 0) begin bad++; $display("FAIL rst_fifo_empty stale=%0d want=0", n_log - base); end
    start_dl(8'd1);
    wr_byte(27'd0, 8'h55);
    wr_byte(27'd1, 8'h66);
    wr_byte(27'd2, 8'h77);
    wr_byte(27'd3, 8'h88);
    end_dl();
    wait_done(dcnt);
    total++; if (n_log - base !== 2) begin bad++; $display("FAIL rst_next_nreq got=%0d want=2", n_log - base); end
    total++; if (log_addr[base] !== 25'h100000 || log_din[base] !== 16'h6655) begin bad++; $display("FAIL rst_next_w0 addr=%h din=%h want 100000 6655", log_addr[base], log_din[base]); end
    total++; if (log_addr[base+1] !== 25'h100001 || log_din[base+1] !== 16'h8877) begin bad++; $display("FAIL rst_next_w1 addr=%h din=%h want 100001 8877", log_addr[base+1], log_din[base+1]); end
    total++; if (byte_count !== 27'd4 || dcnt !== 1) begin bad++; $display("FAIL rst_next_end count=%0d done=%0d want 4 1", byte_count, dcnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_length();
    test_region();
    test_bad_index();
    test_backpressure();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
